boid_frame_sequencer: RTL and testbench

Sequences per-frame updates of the 1-bit boid pixel bitmap that the VGA path reads. On each frame boundary (`screenEnd`), it performs three steps in order:

- erase every pixel it drew last frame;
- fetch each boid's current position from the boid position store over a request/valid handshake;
- write the new boid pixels.

It owns the bitmap's write port. The VGA read port is untouched. After reset it sweeps the whole bitmap to background before accepting frames.

---
 rtl/boid_frame_sequencer_pkg.sv | 35 +++
 rtl/boid_frame_sequencer_if.sv | 37 +++
 rtl/boid_shadow_table.sv | 51 +++++
 rtl/boid_frame_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_boid_frame_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boid_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : boid_pkg
//  Purpose  : Shared constants, sequencer state type and helpers for the
//             boid frame sequencer slice.
//  Contents : VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_COUNT, PIXEL_ADDRESS_WIDTH,
//             BOID_X_WIDTH, BOID_Y_WIDTH, seq_state_t, idx_width()
//  Revision : 1.0 - initial release
// ============================================================================
package boid_pkg;

   localparam int VIDEO_WIDTH         = 640;
   localparam int VIDEO_HEIGHT        = 480;
   localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
   localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT) + 1;

   localparam int BOID_X_WIDTH = 10;
   localparam int BOID_Y_WIDTH = 9;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ERASE = 3'd2,
      ST_FETCH = 3'd3,
      ST_DRAW  = 3'd4,
      ST_DONE  = 3'd5
   } seq_state_t;

   // Index width for a table of n entries; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/boid_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : boid_frame_sequencer_if
//  Purpose  : Position-store request/valid handshake and bitmap write port.
//  Signals  : pos_req, pos_idx, pos_valid, pos_x, pos_y   (position store)
//             mem_wr_en, mem_wr_addr, mem_wr_data         (bitmap write)
//  Modports : master - sequencer side, slave - position store / bitmap side
//  Revision : 1.0 - initial release
// ============================================================================
interface boid_frame_sequencer_if #(
   parameter int IDX_WIDTH  = 4,
   parameter int ADDR_WIDTH = 20
);
   import boid_pkg::*;

   logic                    pos_req;
   logic [IDX_WIDTH-1:0]    pos_idx;
   logic                    pos_valid;
   logic [BOID_X_WIDTH-1:0] pos_x;
   logic [BOID_Y_WIDTH-1:0] pos_y;

   logic                    mem_wr_en;
   logic [ADDR_WIDTH-1:0]   mem_wr_addr;
   logic                    mem_wr_data;

   modport master (
      output pos_req, pos_idx, mem_wr_en, mem_wr_addr, mem_wr_data,
      input  pos_valid, pos_x, pos_y
   );

   modport slave (
      input  pos_req, pos_idx, mem_wr_en, mem_wr_addr, mem_wr_data,
      output pos_valid, pos_x, pos_y
   );

endinterface
`default_nettype wire

// File: rtl/boid_shadow_table.sv
`default_nettype none
// ============================================================================
//  Module   : boid_shadow_table
//  Purpose  : Remembers the pixel address drawn for each boid last frame so
//             it can be erased on the next frame.
//  Ports    : clk, reset         - clock, async active-high reset
//             i_wr_en/idx/addr/valid - synchronous write of one entry
//             i_rd_idx -> o_rd_addr, o_rd_valid - combinational read
//  Revision : 1.0 - initial release
// ============================================================================
module boid_shadow_table #(
   parameter int NUM_BOIDS  = 16,
   parameter int ADDR_WIDTH = 20,
   parameter int IDX_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [IDX_WIDTH-1:0]  i_wr_idx,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic                  i_wr_valid,
   input  logic [IDX_WIDTH-1:0]  i_rd_idx,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic                  o_rd_valid
);

   logic [ADDR_WIDTH-1:0] r_addr [NUM_BOIDS];
   logic [NUM_BOIDS-1:0]  r_valid;

   generate
      for (genvar g = 0; g < NUM_BOIDS; g++) begin : g_entry
         // Address storage is never reset: a cleared valid bit masks it.
         always_ff @(posedge clk) begin
            if (i_wr_en && (i_wr_idx == IDX_WIDTH'(g)))
               r_addr[g] <= i_wr_addr;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               r_valid[g] <= 1'b0;
            else if (i_wr_en && (i_wr_idx == IDX_WIDTH'(g)))
               r_valid[g] <= i_wr_valid;
         end
      end
   endgenerate

   assign o_rd_addr  = r_addr[i_rd_idx];
   assign o_rd_valid = r_valid[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/boid_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : boid_frame_sequencer
//  Purpose  : On each screenEnd rising edge, erase last frame's boid pixels,
//             fetch every boid position and draw the new pixels into the
//             1-bit bitmap. After reset, clears the whole bitmap first.
//  Ports    : clk, reset  - clock, async active-high reset
//             screenEnd   - frame boundary level (rising edge used)
//             bus         - position handshake + bitmap write port (master)
//             busy        - high while not idle
//             frame_done  - one-cycle pulse per completed frame
//             overrun     - sticky: frame edge arrived while busy
//  Revision : 1.0 - initial release
// ============================================================================
module boid_frame_sequencer #(
   parameter int NUM_BOIDS           = 16,
   parameter int VIDEO_WIDTH         = boid_pkg::VIDEO_WIDTH,
   parameter int VIDEO_HEIGHT        = boid_pkg::VIDEO_HEIGHT,
   parameter int PIXEL_ADDRESS_WIDTH = $clog2(VIDEO_WIDTH * VIDEO_HEIGHT) + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   screenEnd,
   boid_frame_sequencer_if.master bus,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   overrun
);
   import boid_pkg::*;

   localparam int c_idx_width = idx_width(NUM_BOIDS);
   localparam logic [c_idx_width-1:0] c_last_boid = c_idx_width'(NUM_BOIDS - 1);
   localparam logic [PIXEL_ADDRESS_WIDTH-1:0] c_last_pixel =
      PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH * VIDEO_HEIGHT - 1);

   seq_state_t                   r_state, w_state_next;
   logic [c_idx_width-1:0]       r_idx, w_idx_next;
   logic [PIXEL_ADDRESS_WIDTH-1:0] r_init_addr, w_init_next;

   logic                         r_se_q, r_se_q2, w_se_rise;
   logic [BOID_X_WIDTH-1:0]      r_x;
   logic [BOID_Y_WIDTH-1:0]      r_y;
   logic                         w_capture;

   logic                         r_wr_en, w_wr_en;
   logic [PIXEL_ADDRESS_WIDTH-1:0] r_wr_addr, w_wr_addr;
   logic                         r_wr_data, w_wr_data;

   logic                         r_pos_req;
   logic                         r_busy, r_frame_done, r_overrun;

   logic                         w_in_range;
   logic [PIXEL_ADDRESS_WIDTH-1:0] w_draw_addr;
   logic                         w_sh_wr;
   logic [PIXEL_ADDRESS_WIDTH-1:0] w_sh_rd_addr;
   logic                         w_sh_rd_valid;

   // Two-stage sampling: the first stage is the registered copy of
   // screenEnd, the second lets us detect its rising edge.
   assign w_se_rise = r_se_q & ~r_se_q2;

   assign w_in_range  = (32'(r_x) < 32'(VIDEO_WIDTH)) && (32'(r_y) < 32'(VIDEO_HEIGHT));
   assign w_draw_addr = PIXEL_ADDRESS_WIDTH'(r_x) +
                        PIXEL_ADDRESS_WIDTH'(VIDEO_WIDTH) * PIXEL_ADDRESS_WIDTH'(r_y);

   boid_shadow_table #(
      .NUM_BOIDS  (NUM_BOIDS),
      .ADDR_WIDTH (PIXEL_ADDRESS_WIDTH),
      .IDX_WIDTH  (c_idx_width)
   ) u_shadow (
      .clk        (clk),
      .reset      (reset),
      .i_wr_en    (w_sh_wr),
      .i_wr_idx   (r_idx),
      .i_wr_addr  (w_draw_addr),
      .i_wr_valid (w_in_range),
      .i_rd_idx   (r_idx),
      .o_rd_addr  (w_sh_rd_addr),
      .o_rd_valid (w_sh_rd_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_INIT;
         r_idx        <= '0;
         r_init_addr  <= '0;
         r_se_q       <= 1'b0;
         r_se_q2      <= 1'b0;
         r_x          <= '0;
         r_y          <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= 1'b0;
         r_pos_req    <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_idx       <= w_idx_next;
         r_init_addr <= w_init_next;
         r_se_q      <= screenEnd;
         r_se_q2     <= r_se_q;
         if (w_capture) begin
            r_x <= bus.pos_x;
            r_y <= bus.pos_y;
         end
         r_wr_en   <= w_wr_en;
         r_wr_addr <= w_wr_addr;
         r_wr_data <= w_wr_data;
         // Request follows the next state so it is already up in the first
         // FETCH cycle, letting an early pos_valid be accepted at once.
         r_pos_req <= (w_state_next == ST_FETCH);
         // Status lags the state by one cycle, lining it up with the
         // registered write port.
         r_busy       <= (r_state != ST_IDLE);
         r_frame_done <= (r_state == ST_DONE);
         if (w_se_rise && (r_state != ST_INIT) && (r_state != ST_IDLE))
            r_overrun <= 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_init_next  = r_init_addr;
      w_wr_en      = 1'b0;
      w_wr_addr    = r_wr_addr;
      w_wr_data    = r_wr_data;
      w_capture    = 1'b0;
      w_sh_wr      = 1'b0;

      case (r_state)
         ST_INIT: begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_init_addr;
            w_wr_data = 1'b0;
            if (r_init_addr == c_last_pixel) begin
               w_init_next  = '0;
               w_state_next = ST_IDLE;
            end else begin
               w_init_next = r_init_addr + PIXEL_ADDRESS_WIDTH'(1);
            end
         end

         ST_IDLE: begin
            if (w_se_rise) begin
               w_idx_next   = '0;
               w_state_next = ST_ERASE;
            end
         end

         ST_ERASE: begin
            if (w_sh_rd_valid) begin
               w_wr_en   = 1'b1;
               w_wr_addr = w_sh_rd_addr;
               w_wr_data = 1'b0;
            end
            if (r_idx == c_last_boid) begin
               w_idx_next   = '0;
               w_state_next = ST_FETCH;
            end else begin
               w_idx_next = r_idx + c_idx_width'(1);
            end
         end

         ST_FETCH: begin
            if (bus.pos_valid) begin
               w_capture    = 1'b1;
               w_state_next = ST_DRAW;
            end
         end

         ST_DRAW: begin
            w_sh_wr = 1'b1;
            if (w_in_range) begin
               w_wr_en   = 1'b1;
               w_wr_addr = w_draw_addr;
               w_wr_data = 1'b1;
            end
            if (r_idx == c_last_boid) begin
               w_idx_next   = '0;
               w_state_next = ST_DONE;
            end else begin
               w_idx_next   = r_idx + c_idx_width'(1);
               w_state_next = ST_FETCH;
            end
         end

         ST_DONE: begin
            w_state_next = ST_IDLE;
         end

         default: begin
            w_state_next = ST_INIT;
         end
      endcase
   end

   assign bus.pos_req     = r_pos_req;
   assign bus.pos_idx     = r_idx;
   assign bus.mem_wr_en   = r_wr_en;
   assign bus.mem_wr_addr = r_wr_addr;
   assign bus.mem_wr_data = r_wr_data;

   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_boid_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boid_frame_sequencer
//  Purpose  : Scoreboard bench for boid_frame_sequencer on an 8x4 bitmap
//             with 4 boids. Expected bitmap writes are queued by the
//             stimulus and consumed by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boid_frame_sequencer;

   localparam int NB = 4;
   localparam int VW = 8;
   localparam int VH = 4;
   localparam int AW = 6;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset;
   logic screenEnd;
   logic busy, frame_done, overrun;

   always #5 clk = ~clk;

   boid_frame_sequencer_if #(.IDX_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

   boid_frame_sequencer #(
      .NUM_BOIDS           (NB),
      .VIDEO_WIDTH         (VW),
      .VIDEO_HEIGHT        (VH),
      .PIXEL_ADDRESS_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .screenEnd  (screenEnd),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  n_done   = 0;
   int  px  [NB];
   int  py  [NB];
   int  dly [NB];

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push_wr(input int addr, input int data);
      wr_t e;
      e.addr = AW'(addr);
      e.data = data[0];
      exp_q.push_back(e);
   endtask

   // Monitor: every observed write must match the head of the queue.
   initial begin : monitor
      wr_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.mem_wr_en === 1'b1) begin
            check("wr_busy", int'(busy), 1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_wr: got addr %0d data %0d expected no write",
                        bus.mem_wr_addr, bus.mem_wr_data);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", int'(bus.mem_wr_addr), int'(e.addr));
               check("wr_data", int'(bus.mem_wr_data), int'(e.data));
            end
         end
         if (frame_done === 1'b1) begin
            n_done++;
            check("done_one_cycle", int'(prev_done), 0);
         end
         prev_done = frame_done;
      end
   end

   // Position store model: answers each request after dly[idx] extra cycles.
   initial begin : pos_store
      int idx;
      bus.pos_valid = 1'b0;
      bus.pos_x     = '1;
      bus.pos_y     = '1;
      forever begin
         @(negedge clk);
         if (bus.pos_req === 1'b1 && reset === 1'b0) begin
            idx = int'(bus.pos_idx);
            for (int k = 0; k < dly[idx]; k++) begin
               @(negedge clk);
               check("req_hold", int'(bus.pos_req), 1);
               check("idx_hold", int'(bus.pos_idx), idx);
               check("no_wr_in_wait", int'(bus.mem_wr_en), 0);
            end
            bus.pos_valid = 1'b1;
            bus.pos_x     = 10'(px[idx]);
            bus.pos_y     = 9'(py[idx]);
            @(negedge clk);
            bus.pos_valid = 1'b0;
            bus.pos_x     = '1;
            bus.pos_y     = '1;
         end
      end
   end

   task automatic init_sweep(input bit poke);
      int cnt;
      int guard;
      int done0;
      cnt   = 0;
      guard = 0;
      done0 = n_done;
      @(negedge clk);
      while (busy === 1'b1 && guard < 200) begin
         cnt++;
         guard++;
         if (poke && cnt == 5) screenEnd = 1'b1;
         if (poke && cnt == 8) screenEnd = 1'b0;
         @(negedge clk);
      end
      screenEnd = 1'b0;
      check("init_busy_cycles", cnt, VW * VH);
      check("init_queue_empty", exp_q.size(), 0);
      check("init_no_done", n_done, done0);
      repeat (20) @(negedge clk);
      check("init_stays_idle", int'(busy), 0);
      check("init_no_overrun", int'(overrun), 0);
   endtask

   task automatic run_frame(input bit mid_pulse);
      int start;
      int k;
      start = n_done;
      screenEnd = 1'b1;
      repeat (3) @(negedge clk);
      screenEnd = 1'b0;
      if (mid_pulse) begin
         k = 0;
         while (bus.pos_req !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("reached_fetch", int'(bus.pos_req), 1);
         screenEnd = 1'b1;
         repeat (2) @(negedge clk);
         screenEnd = 1'b0;
      end
      k = 0;
      while (n_done == start && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("frame_done_seen", n_done, start + 1);
      repeat (3) @(negedge clk);
      check("frame_queue_empty", exp_q.size(), 0);
      check("frame_idle", int'(busy), 0);
   endtask

   initial begin : stimulus
      int k;
      int done0;
      reset     = 1'b1;
      screenEnd = 1'b0;
      dly = '{0, 0, 0, 0};
      px  = '{0, 0, 0, 0};
      py  = '{0, 0, 0, 0};
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_wr_en", int'(bus.mem_wr_en), 0);
      check("rst_wr_addr", int'(bus.mem_wr_addr), 0);
      check("rst_wr_data", int'(bus.mem_wr_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_pos_req", int'(bus.pos_req), 0);
      check("rst_pos_idx", int'(bus.pos_idx), 0);

      // Power-up sweep, with a screenEnd pulse that must be ignored
      for (int a = 0; a < VW * VH; a++) push_wr(a, 0);
      reset = 1'b0;
      init_sweep(1'b1);

      // Frame 1: (1,0) (7,3) (0,2) (3,1)
      px = '{1, 7, 0, 3};
      py = '{0, 3, 2, 1};
      push_wr(1, 1); push_wr(31, 1); push_wr(16, 1); push_wr(11, 1);
      run_frame(1'b0);
      check("f1_overrun", int'(overrun), 0);

      // Frame 2: x+1, boid 1 falls off the right edge
      px = '{2, 8, 1, 4};
      push_wr(1, 0); push_wr(31, 0); push_wr(16, 0); push_wr(11, 0);
      push_wr(2, 1); push_wr(17, 1); push_wr(12, 1);
      run_frame(1'b0);

      // Frame 3: extra screenEnd edge during FETCH
      px = '{5, 6, 0, 7};
      py = '{1, 2, 0, 0};
      push_wr(2, 0); push_wr(17, 0); push_wr(12, 0);
      push_wr(13, 1); push_wr(22, 1); push_wr(0, 1); push_wr(7, 1);
      run_frame(1'b1);
      check("f3_overrun", int'(overrun), 1);
      done0 = n_done;
      repeat (20) @(negedge clk);
      check("f3_no_restart_busy", int'(busy), 0);
      check("f3_no_restart_done", n_done, done0);

      // Frame 4: boid 2 answers after 5 wait cycles
      px  = '{1, 2, 3, 4};
      py  = '{1, 2, 3, 0};
      dly = '{0, 0, 5, 0};
      push_wr(13, 0); push_wr(22, 0); push_wr(0, 0); push_wr(7, 0);
      push_wr(9, 1); push_wr(18, 1); push_wr(27, 1); push_wr(4, 1);
      run_frame(1'b0);
      check("f4_overrun_sticky", int'(overrun), 1);

      // Frame 5: reset during the DRAW of boid 2
      dly = '{0, 0, 0, 0};
      px  = '{0, 1, 2, 3};
      py  = '{1, 1, 1, 1};
      push_wr(9, 0); push_wr(18, 0); push_wr(27, 0); push_wr(4, 0);
      push_wr(8, 1); push_wr(9, 1);
      screenEnd = 1'b1;
      repeat (3) @(negedge clk);
      screenEnd = 1'b0;
      k = 0;
      forever begin
         @(negedge clk);
         #1;
         k++;
         if ((bus.pos_valid === 1'b1 && bus.pos_idx === 2'd2) || k > 200) break;
      end
      check("f5_reached_boid2", int'(bus.pos_idx), 2);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("mrst_wr_en", int'(bus.mem_wr_en), 0);
      check("mrst_busy", int'(busy), 0);
      check("mrst_pos_req", int'(bus.pos_req), 0);
      check("mrst_pos_idx", int'(bus.pos_idx), 0);
      check("mrst_overrun", int'(overrun), 0);
      check("mrst_done", int'(frame_done), 0);
      check("mrst_queue", exp_q.size(), 0);
      exp_q.delete();
      for (int a = 0; a < VW * VH; a++) push_wr(a, 0);
      @(negedge clk);
      reset = 1'b0;
      init_sweep(1'b0);

      // Frame 6: shadow table was cleared, so no erase writes
      px = '{1, 7, 0, 3};
      py = '{0, 3, 2, 1};
      push_wr(1, 1); push_wr(31, 1); push_wr(16, 1); push_wr(11, 1);
      run_frame(1'b0);
      check("f6_overrun", int'(overrun), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
